// File: rtl/bitty_pkg.sv
// bitty_pkg: shared widths and state encoding for the bitty fetch unit.
package bitty_pkg;
    localparam int INSTR_W = 16;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, NEXT} fetch_state_t;
endpackage

// File: rtl/bitty_imem.sv
// bitty_imem: single-write-port instruction RAM with a registered read port and no reset.
module bitty_imem
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: steps a program through bitty_core, one run/done handshake per word.
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic               stop,
    input  logic               done,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               finished,
    output logic               timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    fetch_state_t       state;
    logic [ADDR_W-1:0]  last_q;
    logic [WD_W-1:0]    watchdog;
    logic [INSTR_W-1:0] rdata;
    logic               done_q;
    logic               stop_pending;
    logic               done_rise;
    assign done_rise = done & ~done_q;
    assign busy      = state != IDLE;
    bitty_imem #(.ADDR_W(ADDR_W)) u_imem (
        .clk   (clk),
        .we    (prog_we && state == IDLE),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (rdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            last_q       <= '0;
            instruction  <= '0;
            run          <= 1'b0;
            finished     <= 1'b0;
            timeout_err  <= 1'b0;
            watchdog     <= '0;
            done_q       <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            done_q   <= done;
            finished <= 1'b0;
            if (busy && stop) stop_pending <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    pc           <= start_pc;
                    last_q       <= last_addr;
                    timeout_err  <= 1'b0;
                    stop_pending <= 1'b0;
                    state        <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    instruction <= rdata;
                    run         <= 1'b1;
                    watchdog    <= '0;
                    state       <= EXEC;
                end
                EXEC: begin
                    watchdog <= watchdog + WD_W'(1);
                    // A done level left high from the previous word is not an edge, so it cannot end this one.
                    if (done_rise) begin
                        run   <= 1'b0;
                        state <= NEXT;
                    end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                        run         <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                NEXT: if (pc == last_q || stop_pending) begin
                    finished <= 1'b1;
                    state    <= IDLE;
                end else begin
                    pc    <= pc + ADDR_W'(1);
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb_bitty_fetch_unit: vector table of program runs plus timeout, reset and busy-write sequences.
module tb_bitty_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic [7:0]  last_addr = '0;
    logic        stop = 1'b0;
    logic        done = 1'b0;
    logic [15:0] instruction;
    logic        run;
    logic [7:0]  pc;
    logic        busy;
    logic        finished;
    logic        timeout_err;

    bitty_fetch_unit #(.ADDR_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .start_pc(start_pc), .last_addr(last_addr),
        .stop(stop), .done(done), .instruction(instruction), .run(run), .pc(pc),
        .busy(busy), .finished(finished), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] pc; logic [15:0] instr;} exp_t;
    typedef struct {logic [7:0] sp; logic [7:0] la; int mode; int n; logic [7:0] pc;} vec_t;

    exp_t        sb[$];
    logic [15:0] shadow [256];
    int          total = 0;
    int          bad = 0;
    int          fin_cnt = 0;
    int          runs = 0;
    int          core_cnt = 0;
    bit          core_en = 1'b1;
    logic        run_q = 1'b0;
    logic [15:0] cur = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Core model: done rises on the third sampled cycle of run and drops once run falls.
    always @(negedge clk) begin
        if (run && core_en) begin
            core_cnt++;
            if (core_cnt == 3) done = 1'b1;
        end else begin
            core_cnt = 0;
            done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run && !run_q) begin
            runs++;
            check("sb_avail", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("instr", instruction, e.instr);
                check("pc", pc, e.pc);
                cur = e.instr;
            end
        end else if (run) check("instr_hold", instruction, cur);
        if (finished) begin
            fin_cnt++;
            check("fin_busy", busy, 0);
        end
        run_q = run;
    end

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        shadow[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input vec_t v);
        logic [7:0] a;
        bit seen;
        fin_cnt = 0;
        runs = 0;
        a = v.sp;
        for (int i = 0; i < v.n; i++) begin
            sb.push_back('{a, shadow[a]});
            a++;
        end
        @(negedge clk);
        start_pc = v.sp; last_addr = v.la; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_fetch", busy, 1);
        check("run_fetch", run, 0);
        check("terr_clr", timeout_err, 0);
        @(negedge clk);
        check("run_load", run, 0);
        if (v.mode == 1) stop = 1'b1;
        if (v.mode == 2) begin
            prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'hBEEF;
        end
        @(negedge clk);
        stop = 1'b0; prog_we = 1'b0;
        check("run_exec", run, 1);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (finished) seen = 1'b1;
            else @(negedge clk);
        end
        check("fin_seen", seen, 1);
        check("end_pc", pc, v.pc);
        check("end_busy", busy, 0);
        check("end_terr", timeout_err, 0);
        @(negedge clk);
        check("fin_pulse", finished, 0);
        repeat (3) @(negedge clk);
        check("fin_cnt", fin_cnt, 1);
        check("runs", runs, v.n);
        check("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        vec_t vecs[8];
        int c;
        vecs[0] = '{sp: 8'd0,   la: 8'd2,  mode: 0, n: 3, pc: 8'd2};
        vecs[1] = '{sp: 8'd254, la: 8'd1,  mode: 0, n: 4, pc: 8'd1};
        vecs[2] = '{sp: 8'd0,   la: 8'd2,  mode: 1, n: 1, pc: 8'd0};
        vecs[3] = '{sp: 8'd5,   la: 8'd5,  mode: 0, n: 1, pc: 8'd5};
        vecs[4] = '{sp: 8'd0,   la: 8'd2,  mode: 2, n: 3, pc: 8'd2};
        vecs[5] = '{sp: 8'd0,   la: 8'd0,  mode: 0, n: 1, pc: 8'd0};
        vecs[6] = '{sp: 8'd10,  la: 8'd13, mode: 0, n: 4, pc: 8'd13};
        vecs[7] = '{sp: 8'd250, la: 8'd3,  mode: 1, n: 1, pc: 8'd250};
        #1;
        check("rst_run", run, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_fin", finished, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_instr", instruction, 0);
        @(negedge clk);
        reset = 1'b0;
        load(8'd0, 16'h1111);
        load(8'd1, 16'h2222);
        load(8'd2, 16'h3333);
        for (int i = 3; i < 16; i++) load(8'(i), 16'($urandom));
        for (int i = 248; i < 254; i++) load(8'(i), 16'($urandom));
        load(8'd254, 16'hAAAA);
        load(8'd255, 16'hBBBB);
        for (int i = 0; i < 8; i++) run_prog(vecs[i]);

        // Watchdog: core never answers.
        core_en = 1'b0;
        fin_cnt = 0;
        sb.push_back('{8'd0, shadow[0]});
        @(negedge clk);
        start_pc = 8'd0; last_addr = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!run && c < 10) begin c++; @(negedge clk); end
        check("wd_run_up", run, 1);
        c = 0;
        while (run && c < 200) begin c++; @(negedge clk); end
        check("wd_cycles", c, 64);
        check("wd_terr", timeout_err, 1);
        check("wd_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("wd_terr_hold", timeout_err, 1);
        check("wd_no_fin", fin_cnt, 0);
        core_en = 1'b1;
        run_prog(vecs[0]);

        // Asynchronous reset in the middle of EXEC.
        sb.push_back('{8'd0, shadow[0]});
        @(negedge clk);
        start_pc = 8'd0; last_addr = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!run && c < 10) begin c++; @(negedge clk); end
        check("rs_run_up", run, 1);
        #2 reset = 1'b1;
        #1;
        check("rs_run", run, 0);
        check("rs_pc", pc, 0);
        check("rs_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_prog(vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
